// File: rtl/na_read_sched.sv
// na_read_sched: shares the NA read path between TDM and BE receive endpoints.
// TDM has priority, BE is protected by a starvation guard, round-robin within each class.
module na_read_sched #(
  parameter int NUM_TDM_ENDPOINTS = 1,
  parameter int NUM_BE_ENDPOINTS = 1,
  parameter int BE_STARVE_LIMIT = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int NUM_EP = NUM_TDM_ENDPOINTS + NUM_BE_ENDPOINTS,
  localparam int IDX_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
  input  logic                         clk,
  input  logic                         rst_debug_n,
  input  logic                         enable,
  input  logic [NUM_TDM_ENDPOINTS-1:0] tdm_pending,
  input  logic [NUM_BE_ENDPOINTS-1:0]  be_pending,
  output logic                         grant_valid,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         grant_tdm,
  input  logic                         grant_ready,
  input  logic                         pkt_done,
  input  logic                         pkt_err,
  output logic                         abort,
  output logic                         busy,
  output logic [7:0]                   err_count
);
  localparam int TW = (NUM_TDM_ENDPOINTS > 1) ? $clog2(NUM_TDM_ENDPOINTS) : 1;
  localparam int BW = (NUM_BE_ENDPOINTS > 1) ? $clog2(NUM_BE_ENDPOINTS) : 1;
  localparam int SW = $clog2(BE_STARVE_LIMIT + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_ACTIVE, S_ABORT} state_t;

  state_t r_state, w_next;
  logic [IDX_W-1:0] r_grant_idx;
  logic r_grant_tdm;
  logic [TW-1:0] r_tdm_ptr, r_tdm_off, w_tdm_sel;
  logic [BW-1:0] r_be_ptr, r_be_off, w_be_sel;
  logic [SW-1:0] r_starve;
  logic [CW-1:0] r_tmo;
  logic [7:0] r_err;
  int w_td, w_bd, w_tk, w_bk;
  logic w_force, w_pick_tdm, w_win, w_accept, w_tmo_hit, w_err_inc;
  logic [IDX_W-1:0] w_win_idx;

  // Winner in each class is the pending endpoint with the smallest wrap distance from its pointer.
  always_comb begin
    w_td = NUM_TDM_ENDPOINTS;
    w_tk = 0;
    w_tdm_sel = '0;
    for (int k = 0; k < NUM_TDM_ENDPOINTS; k++) begin
      w_tk = (k >= int'(r_tdm_ptr)) ? k - int'(r_tdm_ptr) : k + NUM_TDM_ENDPOINTS - int'(r_tdm_ptr);
      if (tdm_pending[k] && w_tk < w_td) begin
        w_td = w_tk;
        w_tdm_sel = TW'(k);
      end
    end
    w_bd = NUM_BE_ENDPOINTS;
    w_bk = 0;
    w_be_sel = '0;
    for (int k = 0; k < NUM_BE_ENDPOINTS; k++) begin
      w_bk = (k >= int'(r_be_ptr)) ? k - int'(r_be_ptr) : k + NUM_BE_ENDPOINTS - int'(r_be_ptr);
      if (be_pending[k] && w_bk < w_bd) begin
        w_bd = w_bk;
        w_be_sel = BW'(k);
      end
    end
  end

  assign w_force    = (r_starve >= SW'(BE_STARVE_LIMIT)) && |be_pending;
  assign w_pick_tdm = |tdm_pending && !w_force;
  assign w_win      = |tdm_pending || |be_pending;
  assign w_win_idx  = w_pick_tdm ? IDX_W'(w_tdm_sel) : IDX_W'(NUM_TDM_ENDPOINTS + int'(w_be_sel));
  assign w_accept   = (r_state == S_OFFER) && grant_ready;
  assign w_tmo_hit  = r_tmo == CW'(TIMEOUT_CYCLES - 1);
  // A completion pulse coinciding with the last timeout cycle takes precedence over the abort.
  assign w_err_inc  = (r_state == S_ACTIVE) && (pkt_err || (!pkt_done && w_tmo_hit));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = (enable && w_win) ? S_OFFER : S_IDLE;
      S_OFFER:  w_next = grant_ready ? S_ACTIVE : (!enable ? S_IDLE : S_OFFER);
      S_ACTIVE: w_next = (pkt_done || pkt_err) ? S_IDLE : (w_tmo_hit ? S_ABORT : S_ACTIVE);
      S_ABORT:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_debug_n) begin
    if (!rst_debug_n) begin
      r_state     <= S_IDLE;
      r_grant_idx <= '0;
      r_grant_tdm <= 1'b0;
      r_tdm_ptr   <= '0;
      r_tdm_off   <= '0;
      r_be_ptr    <= '0;
      r_be_off    <= '0;
      r_starve    <= '0;
      r_tmo       <= '0;
      r_err       <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_OFFER) begin
        r_grant_idx <= w_win_idx;
        r_grant_tdm <= w_pick_tdm;
        r_tdm_off   <= w_tdm_sel;
        r_be_off    <= w_be_sel;
      end
      if (r_state == S_ACTIVE)
        r_tmo <= r_tmo + 1'b1;
      if (w_accept) begin
        r_tmo <= '0;
        if (r_grant_tdm) begin
          r_tdm_ptr <= (r_tdm_off == TW'(NUM_TDM_ENDPOINTS - 1)) ? '0 : r_tdm_off + 1'b1;
          r_starve  <= !(|be_pending) ? '0 : ((r_starve == SW'(BE_STARVE_LIMIT)) ? r_starve : r_starve + 1'b1);
        end else begin
          r_be_ptr <= (r_be_off == BW'(NUM_BE_ENDPOINTS - 1)) ? '0 : r_be_off + 1'b1;
          r_starve <= '0;
        end
      end
      if (w_err_inc && r_err != 8'hFF)
        r_err <= r_err + 8'd1;
    end
  end

  assign grant_valid = r_state == S_OFFER;
  assign busy        = r_state == S_ACTIVE;
  assign abort       = r_state == S_ABORT;
  assign grant_idx   = r_grant_idx;
  assign grant_tdm   = r_grant_tdm;
  assign err_count   = r_err;
endmodule

// File: tb/tb_na_read_sched.sv
// tb_na_read_sched: directed and randomized checks of na_read_sched against a
// transaction-level scheduler model (pointers, starvation count, error count).
module tb_na_read_sched;
  localparam int NT = 2, NB = 2, LIM = 2, TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, ready = 1'b0, done = 1'b0, err = 1'b0;
  logic [NT-1:0] tdm_p = '0;
  logic [NB-1:0] be_p = '0;
  logic gv, gt, ab, busy;
  logic [1:0] gi;
  logic [7:0] ec;

  int n_checks = 0, n_errors = 0;
  int m_tptr = 0, m_bptr = 0, m_starve = 0, m_ec = 0;
  int cur_idx = 0;
  int rr_seq[4] = '{0, 1, 0, 1};
  int st_idx[6] = '{0, 0, 3, 0, 0, 3};
  int st_tdm[6] = '{1, 1, 0, 1, 1, 0};

  always #5 clk = ~clk;

  na_read_sched #(
    .NUM_TDM_ENDPOINTS(NT), .NUM_BE_ENDPOINTS(NB),
    .BE_STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_debug_n(rst_n), .enable(enable),
    .tdm_pending(tdm_p), .be_pending(be_p),
    .grant_valid(gv), .grant_idx(gi), .grant_tdm(gt), .grant_ready(ready),
    .pkt_done(done), .pkt_err(err), .abort(ab), .busy(busy), .err_count(ec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the global index the scheduler should choose, or -1 for none.
  function automatic int model_pick(input int tp, input int bp);
    bit force_be = (m_starve >= LIM) && (bp != 0);
    if (tp != 0 && !force_be)
      for (int o = 0; o < NT; o++)
        if (((tp >> ((m_tptr + o) % NT)) & 1) != 0) return (m_tptr + o) % NT;
    if (bp != 0)
      for (int o = 0; o < NB; o++)
        if (((bp >> ((m_bptr + o) % NB)) & 1) != 0) return NT + (m_bptr + o) % NB;
    return -1;
  endfunction

  function automatic void model_accept(input int idx, input int bp);
    if (idx < NT) begin
      m_tptr = (idx + 1) % NT;
      m_starve = (bp != 0) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
    end else begin
      m_bptr = (idx - NT + 1) % NB;
      m_starve = 0;
    end
  endfunction

  function automatic void model_reset();
    m_tptr = 0; m_bptr = 0; m_starve = 0; m_ec = 0;
  endfunction

  // Waits for an offer, checks it, optionally holds ready low, then accepts.
  task automatic start_txn(input int rdly);
    int exp, w;
    if (rdly > 0) ready = 1'b0;
    w = 0;
    while (!gv && w < 20) begin
      tick();
      w++;
    end
    chk("offer_seen", int'(gv), 1);
    exp = model_pick(int'(tdm_p), int'(be_p));
    chk("grant_idx", int'(gi), exp);
    chk("grant_tdm", int'(gt), int'(exp >= 0 && exp < NT));
    cur_idx = int'(gi);
    repeat (rdly) begin
      tick();
      chk("offer_hold", int'(gv) * 4 + int'(gi), 4 + exp);
    end
    ready = 1'b1;
    model_accept(exp, int'(be_p));
    tick();
    chk("busy_on_accept", int'(busy) * 2 + int'(gv), 2);
  endtask

  // kind: 0 = pkt_done, 1 = pkt_err, 2 = both together
  task automatic end_txn(input int dly, input int kind);
    repeat (dly) tick();
    done = (kind != 1);
    err = (kind != 0);
    tick();
    done = 1'b0;
    err = 1'b0;
    if (kind != 0 && m_ec < 255) m_ec++;
    chk("busy_off", int'(busy), 0);
    chk("no_abort", int'(ab), 0);
    chk("err_count", int'(ec), m_ec);
  endtask

  task automatic timeout_txn();
    repeat (TMO - 1) tick();
    chk("abort_early", int'(ab) * 2 + int'(busy), 1);
    tick();
    if (m_ec < 255) m_ec++;
    chk("abort_pulse", int'(ab) * 2 + int'(busy), 2);
    chk("abort_err_count", int'(ec), m_ec);
    tick();
    chk("abort_one_cycle", int'(ab) * 2 + int'(gv), 0);
  endtask

  task automatic withdraw();
    int exp, sv, tp, bp;
    ready = 1'b0;
    tick();
    exp = model_pick(int'(tdm_p), int'(be_p));
    chk("wd_offer", int'(gv), 1);
    chk("wd_idx", int'(gi), exp);
    sv = int'(gi);
    tp = int'(tdm_p);
    bp = int'(be_p);
    tdm_p = '0;
    be_p = '0;
    tick();
    chk("wd_stable", int'(gv) * 4 + int'(gi), 4 + sv);
    tdm_p = NT'(tp);
    be_p = NB'(bp);
    enable = 1'b0;
    tick();
    chk("wd_withdrawn", int'(gv), 0);
    enable = 1'b1;
    ready = 1'b1;
    start_txn(0);
    chk("wd_reoffer", cur_idx, sv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    repeat (4) begin
      enable = 1'($urandom); ready = 1'($urandom); done = 1'($urandom); err = 1'($urandom);
      tdm_p = NT'($urandom); be_p = NB'($urandom);
      tick();
      chk("reset_outputs", int'({gv, gi, gt, ab, busy, ec}), 0);
    end
    enable = 1'b1; ready = 1'b1; done = 1'b0; err = 1'b0; tdm_p = '0; be_p = '0;
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_after_reset", int'(gv), 0);
    end

    tdm_p = 2'b11;
    for (int i = 0; i < 4; i++) begin
      start_txn(0);
      chk("rr_seq", cur_idx, rr_seq[i]);
      end_txn(2, 0);
    end

    tdm_p = 2'b01;
    be_p = 2'b10;
    for (int i = 0; i < 6; i++) begin
      start_txn(0);
      chk("starve_idx", cur_idx, st_idx[i]);
      chk("starve_tdm", int'(gt), st_tdm[i]);
      end_txn(2, 0);
    end

    be_p = '0;
    start_txn(0);
    timeout_txn();
    tick();
    chk("regrant_after_abort", int'(gv), 1);
    start_txn(0);
    end_txn(2, 0);
    start_txn(0);
    end_txn(TMO - 1, 0);

    tdm_p = 2'b11;
    withdraw();
    end_txn(1, 1);
    start_txn(0);
    end_txn(0, 2);

    for (int it = 0; it < 120; it++) begin
      tdm_p = NT'($urandom_range(0, 3));
      be_p = NB'($urandom_range(0, 3));
      if (tdm_p == '0 && be_p == '0) begin
        tick();
        tick();
        chk("idle_no_offer", int'(gv), 0);
        continue;
      end
      if ($urandom_range(0, 5) == 0) withdraw();
      else start_txn(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      k = $urandom_range(0, 9);
      if (k == 0) timeout_txn();
      else end_txn($urandom_range(0, TMO - 1), (k < 7) ? 0 : ((k < 9) ? 1 : 2));
    end

    tdm_p = 2'b11;
    be_p = '0;
    start_txn(0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", int'(busy) * 2 + int'(gv), 0);
    chk("async_reset_err", int'(ec), 0);
    model_reset();
    tdm_p = 2'b10;
    tick();
    rst_n = 1'b1;
    start_txn(0);
    chk("post_reset_idx", cur_idx, 1);
    end_txn(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/na_read_sched.md
# na_read_sched

Scheduler that shares the debug-interconnect NA read path between the TDM and BE receive endpoints of one network adapter. It consumes per-endpoint "packet pending" flags, picks one endpoint, and offers it to the NA read FSM over a valid/ready grant handshake. It then holds that grant until the read FSM reports the packet done, errored, or timed out. TDM endpoints get priority, with a starvation guard for BE; selection within each class is round-robin.

## Interface
Parameters:
- NUM_TDM_ENDPOINTS, 1, number of TDM endpoints; mapped to global indices 0..NUM_TDM_ENDPOINTS-1
- NUM_BE_ENDPOINTS, 1, number of BE endpoints; mapped to global indices NUM_TDM_ENDPOINTS..NUM_EP-1
- BE_STARVE_LIMIT, 8, consecutive TDM grants allowed while BE is pending before BE is forced (≥1)
- TIMEOUT_CYCLES, 1024, maximum ACTIVE cycles before abort (≥2)
- localparam NUM_EP = NUM_TDM_ENDPOINTS + NUM_BE_ENDPOINTS; IDX_W = max(1, $clog2(NUM_EP))

Ports:
- clk  in  1  system clock
- rst_debug_n  in  1  asynchronous, active-low reset
- enable  in  1  scheduling enable; gates new offers only
- tdm_pending  in  NUM_TDM_ENDPOINTS  level flag: endpoint holds a received packet
- be_pending  in  NUM_BE_ENDPOINTS  level flag: endpoint holds a received packet
- grant_valid  out  1  offer valid
- grant_idx  out  IDX_W  offered/active global endpoint index
- grant_tdm  out  1  offered/active endpoint is TDM
- grant_ready  in  1  read FSM accepts offer
- pkt_done  in  1  one-cycle pulse: last flit of granted packet read
- pkt_err  in  1  one-cycle pulse: wishbone error during granted packet
- abort  out  1  one-cycle pulse: timeout, read FSM must drop the packet
- busy  out  1  state is ACTIVE
- err_count  out  8  saturating count of pkt_err plus timeouts

## Operation
- Reset (async, immediate): state IDLE; grant_valid, grant_idx, grant_tdm, busy, abort, err_count = 0; tdm_ptr, be_ptr, starve_cnt, timeout counter = 0.
- Selection (combinational, evaluated in IDLE):
  - force_be = (starve_cnt ≥ BE_STARVE_LIMIT) and |be_pending.
  - If |tdm_pending and not force_be: pick the first set TDM bit at or after tdm_ptr, wrapping.
  - Else if |be_pending: pick the first set BE bit at or after be_ptr, wrapping.
  - Else: no winner.
- States:
  - IDLE: if enable and a winner exists, register grant_idx/grant_tdm and go to OFFER.
  - OFFER: grant_valid=1; grant_idx and grant_tdm stay stable even if pending drops.
    - grant_ready → ACTIVE. The class pointer is set to the granted in-class index +1, mod class size.
    - On a TDM accept: starve_cnt+1, saturating at BE_STARVE_LIMIT, only if |be_pending; otherwise starve_cnt=0.
    - On a BE accept: starve_cnt=0.
    - enable=0 and grant_ready=0 → IDLE; the offer is withdrawn and pointers are unchanged.
  - ACTIVE: busy=1; the timeout counter increments each cycle.
    - pkt_done → IDLE.
    - pkt_err → IDLE, err_count+1.
    - Counter reaching TIMEOUT_CYCLES-1 with neither pulse present → ABORT.
    - enable=0 has no effect; the current packet completes.
  - ABORT: abort=1 for exactly one cycle, err_count+1, then IDLE. The counter clears on every ACTIVE entry.
- Simultaneous events:
  - pkt_done and pkt_err together: counts as an error.
  - pkt_done or pkt_err in the same cycle as the timeout: the pulse wins, no abort.
  - pkt_done or pkt_err outside ACTIVE: ignored.
- err_count saturates at 255.

## Timing
- Pending seen in IDLE at cycle t → grant_valid=1 at t+1.
- Accept at cycle a → busy=1 from a+1.
- pkt_done at cycle d → busy=0 at d+1; the earliest next grant_valid is d+2.
- Timeout: entry to ACTIVE at cycle e with no pulse → abort high at cycle e+TIMEOUT_CYCLES, busy=0 that cycle, next offer no earlier than e+TIMEOUT_CYCLES+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use NUM_TDM=2, NUM_BE=2, BE_STARVE_LIMIT=2, TIMEOUT_CYCLES=16, grant_ready tied 1, and pkt_done 3 cycles after accept, unless stated otherwise.
- Reset: drive random inputs while rst_debug_n=0 → all outputs 0. Release with all pending=0 → grant_valid stays 0.
- TDM round-robin: tdm_pending=2'b11, be_pending=0 → grant_idx sequence 0,1,0,1, with grant_tdm=1 each time.
- Starvation guard: tdm_pending=2'b01, be_pending=2'b10 held → grant_idx sequence 0,0,3,0,0,3, with grant_tdm 1,1,0,1,1,0.
- Timeout: accept, then no pkt_done → abort pulses exactly 16 cycles after ACTIVE entry, err_count=1, next grant 2 cycles later. Variant: pkt_done in that same cycle → no abort, err_count=0.
- Withdraw and error: grant_ready=0, enable dropped during OFFER → grant_valid=0 next cycle and pointer unchanged (same index re-offered). pkt_err in ACTIVE → IDLE, err_count+1.
- Reset mid-ACTIVE: assert rst_debug_n=0 while busy=1 → busy and grant_valid 0 immediately. After release with tdm_pending=2'b10 → grant_idx=1 (search starts from ptr 0).
